// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO controller: default geometry,
// occupancy thresholds, the wrap-bit pointer type and the per-cycle
// operation encoding used by the occupancy counter.
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 5;
    localparam int FIFO_AF_THRESH  = 28;
    localparam int FIFO_AE_THRESH  = 4;
    localparam int FIFO_DEPTH      = 1 << FIFO_ADDR_WIDTH;

    // Pointer with one extra MSB used as the wrap bit.
    typedef logic [FIFO_ADDR_WIDTH:0] fifo_ptr_t;

    // Accepted operations in one cycle: {push, pop}.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer register. Increments on inc and wraps modulo
// 2*DEPTH because the extra MSB toggles on every pass through storage.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                inc,
    output logic [ADDR_WIDTH:0] ptr
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    // Pointer register: clear has priority, otherwise advance on inc.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + PTR_ONE;
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller for an external storage array. Produces write enable,
// write/read addresses, occupancy count, level flags and sticky
// overflow/underflow flags. No data passes through this block.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int AF_THRESH  = FIFO_AF_THRESH,
    parameter int AE_THRESH  = FIFO_AE_THRESH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  wr,
    input  logic                  rd,
    output logic                  w_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] AF_LVL  = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_LVL  = (ADDR_WIDTH+1)'(AE_THRESH);

    // Reject illegal threshold combinations when the design is elaborated.
    if (!((AE_THRESH < AF_THRESH) && (AF_THRESH <= DEPTH))) begin : g_bad_thresh
        $error("fifo_ctrl: thresholds must satisfy AE_THRESH < AF_THRESH <= DEPTH");
    end

    logic [ADDR_WIDTH:0] w_ptr;
    logic [ADDR_WIDTH:0] r_ptr;
    logic [ADDR_WIDTH:0] count_q;
    logic                push_acc;
    logic                pop_acc;
    logic                ovf_set;
    logic                unf_set;
    logic                ovf_q;
    logic                unf_q;
    fifo_op_e            op;

    // Level flags come only from registered pointers and count, so there is
    // no combinational path from wr/rd into them.
    assign empty        = (w_ptr == r_ptr);
    assign full         = (w_ptr[ADDR_WIDTH] != r_ptr[ADDR_WIDTH]) &&
                          (w_ptr[ADDR_WIDTH-1:0] == r_ptr[ADDR_WIDTH-1:0]);
    assign almost_full  = (count_q >= AF_LVL);
    assign almost_empty = (count_q <= AE_LVL);
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
    assign w_addr       = w_ptr[ADDR_WIDTH-1:0];
    assign r_addr       = r_ptr[ADDR_WIDTH-1:0];

    // Storage must never be written while reset is held; the pointer flops
    // are already frozen by reset, so only the outgoing enable is gated.
    assign w_en = push_acc & rst_n;

    // Accept logic: a pop frees a slot for a push in the same cycle, so a
    // full FIFO can still take a write alongside a read. clr blocks both.
    // NOTE: every always_comb output gets a value on every path (here by
    // unconditional assignment) so no latch is inferred.
    always_comb begin
        pop_acc  = rd & ~empty & ~clr;
        push_acc = wr & ~clr & (~full | pop_acc);
        ovf_set  = wr & ~clr & ~push_acc;
        unf_set  = rd & ~clr & empty;
        op       = fifo_op_e'({push_acc, pop_acc});
    end

    fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (push_acc),
        .ptr   (w_ptr)
    );

    fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (pop_acc),
        .ptr   (r_ptr)
    );

    // Occupancy counter tracks the pointer difference on the same edge.
    // NOTE: only control state is reset; the external storage array keeps
    // its contents, which become unreachable once the pointers return to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else begin
            case (op)
                OP_PUSH: count_q <= count_q + CNT_ONE;
                OP_POP:  count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky error flags, cleared only by clr or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (clr) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | ovf_set;
            unf_q <= unf_q | unf_set;
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl: reset, fill and wrap, overflow, drain,
// underflow, clear, a randomised push/pop run against a reference model,
// and an asynchronous reset in the middle of a cycle.
module tb_fifo_ctrl;
    import fifo_pkg::*;

    localparam int AW = FIFO_ADDR_WIDTH;

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic          wr;
    logic          rd;
    logic          w_en;
    logic [AW-1:0] w_addr;
    logic [AW-1:0] r_addr;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    int total = 0;
    int bad   = 0;

    fifo_ctrl #(
        .ADDR_WIDTH (FIFO_ADDR_WIDTH),
        .AF_THRESH  (FIFO_AF_THRESH),
        .AE_THRESH  (FIFO_AE_THRESH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .wr           (wr),
        .rd           (rd),
        .w_en         (w_en),
        .w_addr       (w_addr),
        .r_addr       (r_addr),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply inputs and let combinational outputs settle.
    task automatic drive(input logic w, input logic r, input logic c);
        wr  = w;
        rd  = r;
        clr = c;
        #1;
    endtask

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_reset(input string pfx);
        check({pfx, "_count"}, 32'(count), 32'd0);
        check({pfx, "_empty"}, 32'(empty), 32'd1);
        check({pfx, "_full"}, 32'(full), 32'd0);
        check({pfx, "_ae"}, 32'(almost_empty), 32'd1);
        check({pfx, "_af"}, 32'(almost_full), 32'd0);
        check({pfx, "_ovf"}, 32'(overflow), 32'd0);
        check({pfx, "_unf"}, 32'(underflow), 32'd0);
        check({pfx, "_waddr"}, 32'(w_addr), 32'd0);
        check({pfx, "_raddr"}, 32'(r_addr), 32'd0);
    endtask

    initial begin
        fifo_ptr_t m_wp;
        fifo_ptr_t m_rp;
        int        m_cnt;
        logic      m_ovf;
        logic      m_unf;
        logic      w;
        logic      r;
        logic      exp_push;
        logic      exp_pop;

        // Reset state, including w_en held low while wr is asserted.
        rst_n = 1'b0;
        wr    = 1'b0;
        rd    = 1'b0;
        clr   = 1'b0;
        #1;
        check_idle_reset("rst");
        wr = 1'b1;
        #1;
        check("rst_wen", 32'(w_en), 32'd0);
        wr = 1'b0;
        #10;
        rst_n = 1'b1;
        tick();

        // Fill with 32 pushes; almost_full from 28, w_addr wraps 31 -> 0.
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            check("fill_wen", 32'(w_en), 32'd1);
            check("fill_waddr", 32'(w_addr), 32'(i));
            check("fill_af", 32'(almost_full), (i >= 28) ? 32'd1 : 32'd0);
            check("fill_full_pre", 32'(full), 32'd0);
            tick();
            check("fill_count", 32'(count), 32'(i + 1));
        end
        check("fill_full", 32'(full), 32'd1);
        check("fill_af_end", 32'(almost_full), 32'd1);
        check("fill_empty", 32'(empty), 32'd0);
        check("fill_ae", 32'(almost_empty), 32'd0);
        check("fill_wrap", 32'(w_addr), 32'd0);
        check("fill_raddr", 32'(r_addr), 32'd0);

        // Write into a full FIFO is dropped and overflow sticks.
        drive(1'b1, 1'b0, 1'b0);
        check("ovf_wen", 32'(w_en), 32'd0);
        tick();
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd32);
        check("ovf_waddr", 32'(w_addr), 32'd0);
        drive(1'b0, 1'b0, 1'b0);
        tick();
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Simultaneous push and pop while full: both accepted.
        drive(1'b1, 1'b1, 1'b0);
        check("fullrw_wen", 32'(w_en), 32'd1);
        tick();
        check("fullrw_count", 32'(count), 32'd32);
        check("fullrw_full", 32'(full), 32'd1);
        check("fullrw_waddr", 32'(w_addr), 32'd1);
        check("fullrw_raddr", 32'(r_addr), 32'd1);
        check("fullrw_ovf", 32'(overflow), 32'd1);

        // Drain with pops only; almost_empty once count <= 4.
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            check("drain_ae", 32'(almost_empty), ((32 - i) <= 4) ? 32'd1 : 32'd0);
            check("drain_wen", 32'(w_en), 32'd0);
            tick();
            check("drain_count", 32'(count), 32'(31 - i));
        end
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_unf", 32'(underflow), 32'd0);
        check("drain_raddr", 32'(r_addr), 32'd1);

        // Pop from empty: state unchanged, underflow set.
        drive(1'b0, 1'b1, 1'b0);
        tick();
        check("unf_flag", 32'(underflow), 32'd1);
        check("unf_count", 32'(count), 32'd0);
        check("unf_raddr", 32'(r_addr), 32'd1);

        // Push and pop while empty: only the push is taken.
        drive(1'b1, 1'b1, 1'b0);
        check("emptyrw_wen", 32'(w_en), 32'd1);
        check("emptyrw_empty_pre", 32'(empty), 32'd1);
        tick();
        check("emptyrw_count", 32'(count), 32'd1);
        check("emptyrw_unf", 32'(underflow), 32'd1);
        check("emptyrw_empty", 32'(empty), 32'd0);
        check("emptyrw_raddr", 32'(r_addr), 32'd1);
        check("emptyrw_waddr", 32'(w_addr), 32'd2);

        // Bring count to 10, then clear with wr asserted.
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            tick();
        end
        check("preclr_count", 32'(count), 32'd10);
        drive(1'b1, 1'b0, 1'b1);
        check("clr_wen", 32'(w_en), 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        check_idle_reset("clr");

        // Randomised push/pop run against a reference model.
        m_wp  = '0;
        m_rp  = '0;
        m_cnt = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        for (int i = 0; i < 100; i++) begin
            w = ($urandom_range(0, 9) < 8);
            r = ($urandom_range(0, 9) < ((i < 50) ? 3 : 7));
            exp_pop  = r && (m_cnt > 0);
            exp_push = w && ((m_cnt < FIFO_DEPTH) || exp_pop);
            drive(w, r, 1'b0);
            check("rnd_wen", 32'(w_en), 32'(exp_push));
            if (w && !exp_push) m_ovf = 1'b1;
            if (r && (m_cnt == 0)) m_unf = 1'b1;
            tick();
            if (exp_push) m_wp = m_wp + 1'b1;
            if (exp_pop)  m_rp = m_rp + 1'b1;
            m_cnt = m_cnt + (exp_push ? 1 : 0) - (exp_pop ? 1 : 0);
            check("rnd_count", 32'(count), 32'(m_cnt));
            check("rnd_empty", 32'(empty), (m_cnt == 0) ? 32'd1 : 32'd0);
            check("rnd_full", 32'(full), (m_cnt == FIFO_DEPTH) ? 32'd1 : 32'd0);
            check("rnd_waddr", 32'(w_addr), 32'(m_wp[AW-1:0]));
            check("rnd_raddr", 32'(r_addr), 32'(m_rp[AW-1:0]));
            check("rnd_ovf", 32'(overflow), 32'(m_ovf));
            check("rnd_unf", 32'(underflow), 32'(m_unf));
        end

        // Asynchronous reset in the middle of a cycle at count 17.
        drive(1'b0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0);
        check("pre_arst_count", 32'(count), 32'd17);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_reset("arst");
        #2;
        rst_n = 1'b1;
        tick();

        // The first edge after release may accept a push.
        drive(1'b1, 1'b0, 1'b0);
        check("post_rst_wen", 32'(w_en), 32'd1);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        check("post_rst_count", 32'(count), 32'd1);
        check("post_rst_empty", 32'(empty), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
- Parameters (name, default, meaning):
  - REQ-001: ADDR_WIDTH, 5, storage address width; depth DEPTH = 2^ADDR_WIDTH = 32.
  - REQ-002: AF_THRESH, 28, almost_full threshold in entries.
  - REQ-003: AE_THRESH, 4, almost_empty threshold in entries.
- Ports (name, direction, width, meaning):
  - REQ-004: clk, in, 1, single clock; all state on rising edge.
  - REQ-005: rst_n, in, 1, asynchronous active-low reset.
  - REQ-006: clr, in, 1, synchronous clear of pointers, count and error flags.
  - REQ-007: wr, in, 1, push request; data is presented to storage by the producer.
  - REQ-008: rd, in, 1, pop request; head word is taken from storage read data in the same cycle.
  - REQ-009: w_en, out, 1, storage write enable, qualified push.
  - REQ-010: w_addr, out, ADDR_WIDTH, storage write address (tail).
  - REQ-011: r_addr, out, ADDR_WIDTH, storage read address (head).
  - REQ-012: full / empty, out, 1 each, occupancy == DEPTH / occupancy == 0.
  - REQ-013: almost_full / almost_empty, out, 1 each, count >= AF_THRESH / count <= AE_THRESH.
  - REQ-014: count, out, ADDR_WIDTH+1, current occupancy 0..DEPTH.
  - REQ-015: overflow / underflow, out, 1 each, sticky error flags.

Function
- REQ-016: Write and read pointers SHALL be ADDR_WIDTH+1 bits wide; the MSB is the wrap bit, and w_addr / r_addr are the low ADDR_WIDTH bits.
- REQ-017: The block SHALL assert full when the pointer MSBs differ and the low bits are equal, and SHALL assert empty when the pointers are equal.
- REQ-018: Push is accepted when wr=1 and (full=0, or rd accepted in the same cycle); w_en SHALL equal push-accepted combinationally.
- REQ-019: Pop is accepted when rd=1 and empty=0.
- REQ-020: An accepted push SHALL increment the write pointer at the clock edge; an accepted pop SHALL increment the read pointer at the clock edge. Pointers wrap modulo 2*DEPTH.
- REQ-021: count SHALL update on the same edge: +1 for push only, -1 for pop only, unchanged for both or neither.
- REQ-022: When full and wr=1 and rd=1, both SHALL be accepted and count stays at DEPTH.
- REQ-023: When empty and wr=1 and rd=1, push SHALL be accepted, pop SHALL be rejected, and underflow SHALL be set.
- REQ-024: wr=1 while full with rd=0 SHALL drop the write (w_en=0) and set overflow.
- REQ-025: rd=1 while empty SHALL leave state unchanged and set underflow.
- REQ-026: overflow and underflow SHALL remain set until clr or reset.
- REQ-027: All flags and count SHALL be registered, or derived combinationally from registered pointers only, with no combinational path from wr/rd to flags.
- REQ-028: After the first push into an empty FIFO, empty SHALL deassert on the following cycle; r_addr then addresses the valid head word.
- REQ-029: clr SHALL take priority over wr/rd: pointers=0, count=0, overflow=underflow=0, and w_en=0 in that cycle.
- REQ-030: Parameter legality is AE_THRESH < AF_THRESH <= DEPTH; violations SHALL be flagged at elaboration.

Reset
- REQ-031: rst_n low SHALL asynchronously force pointers=0, count=0, overflow=underflow=0.
- REQ-032: During reset, outputs SHALL be empty=1, almost_empty=1, full=0, almost_full=0, and w_en=0.
- REQ-033: Reset asserted mid-operation SHALL discard all contents; storage data is not cleared.
- REQ-034: Deassertion SHALL be synchronized externally; the first edge after release may accept a push.

Structure
- REQ-035: Package fifo_pkg SHALL hold the default constants for ADDR_WIDTH, AF_THRESH and AE_THRESH, plus a typedef for the ADDR_WIDTH+1 pointer.
- REQ-036: The pointer register with increment/wrap SHALL be one sub-module, fifo_ptr, instantiated twice (write and read).
- REQ-037: Storage is external; this block SHALL contain no data path.

Verification
- REQ-038: Reset, then 32 pushes with no pops -> count=32, full=1, almost_full asserted from count=28, w_addr wraps 31->0.
- REQ-039: Full, then wr=1 rd=0 -> w_en=0, overflow=1 sticky; then wr=1 rd=1 -> both accepted, count stays 32.
- REQ-040: Empty, rd=1 -> underflow=1, count=0; then wr=1 rd=1 -> count=1, underflow stays 1.
- REQ-041: 100 random push/pop cycles with a reference counter -> count, empty, full and pointers match every cycle, including two full wraps.
- REQ-042: Count=10, clr=1 with wr=1 -> next cycle count=0, empty=1, flags cleared, w_en=0 during clr.
- REQ-043: rst_n pulsed low mid-cycle at count=17 -> outputs reset immediately without a clock edge.
